mac_seq: RTL and testbench
==========================

MAC_SEQ -- requirements
Module: mac_seq

Interface
REQ-001 Parameter LEN_W, default 8, width of the dot-product length field.
REQ-002 clk  in  1  sole clock, all state on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 start  in  1  single-cycle request to begin a dot product; honoured only in IDLE.
REQ-005 cfg_len  in  LEN_W  number of operand pairs, sampled when start is honoured.
REQ-006 busy  out  1  high in every state except IDLE.
REQ-007 in_valid / in_ready  in / out  1 / 1  operand-pair handshake.
REQ-008 in_a, in_b  in  16 / 16  signed operands.
REQ-009 dsp_a_value, dsp_b_value  out  16 / 16  registered operands to the MAC cell.
REQ-010 dsp_aen, dsp_ben, dsp_men, dsp_sen, dsp_sreset  out  1 each  registered MAC-cell enables.
REQ-011 dsp_s_out, dsp_sat  in  16 / 1  MAC-cell result and saturation flag.
REQ-012 res_valid / res_ready  out / in  1 / 1  result handshake.
REQ-013 res_data, res_sat  out  16 / 1  captured result and its saturation flag.

Function
REQ-014 States: IDLE, RUN, DRAIN, HOLD.
- IDLE->RUN on start with cfg_len!=0.
- RUN->DRAIN on acceptance of the cfg_len-th pair.
- DRAIN->HOLD when the result is captured.
- HOLD->IDLE on res_valid&res_ready.
REQ-015 start with cfg_len==0, or start outside IDLE, SHALL be ignored.
REQ-016 in_ready SHALL equal (state==RUN); a pair is accepted on in_valid&in_ready.
REQ-017 Pipeline timing for a pair accepted at edge ending cycle t:
- t+1: dsp_aen=dsp_ben=1, dsp_a_value=in_a, dsp_b_value=in_b.
- t+2: dsp_men=1.
- t+3: dsp_sen=1 for pairs 1..cfg_len-1; dsp_sreset=1 (and dsp_sen=0) for the last pair.
REQ-018 Enables SHALL be low in any cycle with no corresponding accepted pair; back-to-back and gapped input SHALL both be supported without loss.
REQ-019 For the last pair: dsp_s_out/dsp_sat are captured at the edge ending t+4; res_valid=1, res_data and res_sat hold from t+5.
REQ-020 res_data and res_sat SHALL hold stable while res_valid=1 and res_ready=0.
REQ-021 A remaining-pair counter of LEN_W bits SHALL load cfg_len on start and decrement per accepted pair; no wrap below zero.
REQ-022 dsp_a_value and dsp_b_value SHALL retain their last value when dsp_aen=0.
REQ-023 The result is the 16-bit saturated sum of cfg_len signed products; saturation arithmetic is performed by the MAC cell, not here.

Reset
REQ-024 rst high SHALL immediately force:
- state=IDLE, counter=0.
- All dsp_* outputs, res_valid, res_data and res_sat = 0.
- sat_cnt=0 when compiled in.
REQ-025 rst asserted mid-operation SHALL abandon in-flight pairs; the next operation starts cleanly after rst deasserts.

Configuration
REQ-026 Macro MAC_SEQ_SAT_CNT_EN defined:
- Adds output sat_cnt[15:0].
- Increments on each result capture with dsp_sat=1.
- Saturates at 16'hFFFF.
REQ-027 Macro MAC_SEQ_SAT_CNT_EN undefined: the port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-028 cfg_len=3, pairs (2,3),(4,5),(-1,6) back-to-back, res_ready=1 -> dsp_sen high 2 cycles, dsp_sreset 1 cycle, res_data=20, res_sat=0.
REQ-029 cfg_len=2, pairs (16'h7FFF,16'h7FFF) twice -> res_data=16'h7FFF, res_sat=1, sat_cnt=1 (macro on).
REQ-030 cfg_len=4 with in_valid low every other cycle -> enables gapped accordingly, result equals the ideal sum, in_ready=1 only in RUN.
REQ-031 res_ready held 0 for 10 cycles after res_valid -> res_data stable, start ignored, in_ready=0 until handshake, then IDLE.
REQ-032 rst pulsed after the 2nd of 4 pairs, then cfg_len=1 pair (3,-7) -> all outputs 0 during rst, next res_data=16'hFFEB.
REQ-033 start with cfg_len=0 -> busy stays 0, no dsp enables asserted.

Source files
------------

// File: rtl/mac_seq.sv
// Sequencer that streams signed operand pairs into an external MAC cell and returns the saturated dot product.
// Optional saturation-event counter output sat_cnt is built when MAC_SEQ_SAT_CNT_EN is defined.
module mac_seq #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] cfg_len,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_a,
    input  logic [15:0]      in_b,
    output logic [15:0]      dsp_a_value,
    output logic [15:0]      dsp_b_value,
    output logic             dsp_aen,
    output logic             dsp_ben,
    output logic             dsp_men,
    output logic             dsp_sen,
    output logic             dsp_sreset,
    input  logic [15:0]      dsp_s_out,
    input  logic             dsp_sat,
`ifdef MAC_SEQ_SAT_CNT_EN
    output logic [15:0]      sat_cnt,
`endif
    output logic             res_valid,
    input  logic             res_ready,
    output logic [15:0]      res_data,
    output logic             res_sat
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_HOLD
    } state_e;

    state_e           state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [15:0]      a_q, a_d, b_q, b_d;
    logic             aen_q, aen_d, men_q, men_d, sen_q, sen_d, sreset_q, sreset_d;
    logic             last1_q, last1_d, last2_q, last2_d, cap_q, cap_d;
    logic             res_valid_q, res_valid_d, res_sat_q, res_sat_d;
    logic [15:0]      res_data_q, res_data_d;
    logic             accept, last;

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_sat_d   = res_sat_q;
        accept      = in_valid && (state_q == ST_RUN);
        last        = accept && (cnt_q == LEN_W'(1));

        case (state_q)
            ST_IDLE: begin
                if (start && (cfg_len != '0)) begin
                    state_d = ST_RUN;
                    cnt_d   = cfg_len;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    if (cnt_q != '0) cnt_d = cnt_q - LEN_W'(1);
                    if (last) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: if (cap_q) state_d = ST_HOLD;
            ST_HOLD:  if (res_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        if (accept) begin
            a_d = in_a;
            b_d = in_b;
        end

        // Each accepted pair walks a three-stage enable pipeline; the last-pair tag rides alongside.
        aen_d    = accept;
        men_d    = aen_q;
        last1_d  = last;
        last2_d  = last1_q;
        sen_d    = men_q && !last2_q;
        sreset_d = men_q && last2_q;
        cap_d    = sreset_q;

        if (cap_q) begin
            res_valid_d = 1'b1;
            res_data_d  = dsp_s_out;
            res_sat_d   = dsp_sat;
        end else if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            aen_q       <= 1'b0;
            men_q       <= 1'b0;
            sen_q       <= 1'b0;
            sreset_q    <= 1'b0;
            last1_q     <= 1'b0;
            last2_q     <= 1'b0;
            cap_q       <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_sat_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            aen_q       <= aen_d;
            men_q       <= men_d;
            sen_q       <= sen_d;
            sreset_q    <= sreset_d;
            last1_q     <= last1_d;
            last2_q     <= last2_d;
            cap_q       <= cap_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_sat_q   <= res_sat_d;
        end
    end

`ifdef MAC_SEQ_SAT_CNT_EN
    logic [15:0] sat_cnt_q, sat_cnt_d;

    always_comb begin
        sat_cnt_d = sat_cnt_q;
        if (cap_q && dsp_sat && (sat_cnt_q != 16'hFFFF)) sat_cnt_d = sat_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sat_cnt_q <= '0;
        else     sat_cnt_q <= sat_cnt_d;
    end

    assign sat_cnt = sat_cnt_q;
`endif

    assign busy        = (state_q != ST_IDLE);
    assign in_ready    = (state_q == ST_RUN);
    assign dsp_a_value = a_q;
    assign dsp_b_value = b_q;
    assign dsp_aen     = aen_q;
    assign dsp_ben     = aen_q;
    assign dsp_men     = men_q;
    assign dsp_sen     = sen_q;
    assign dsp_sreset  = sreset_q;
    assign res_valid   = res_valid_q;
    assign res_data    = res_data_q;
    assign res_sat     = res_sat_q;

endmodule

// File: tb/tb_mac_seq.sv
// Self-checking bench for mac_seq: behavioural MAC cell, per-cycle timing monitor, directed and random dot products.
// Build with MAC_SEQ_SAT_CNT_EN defined to also check the saturation counter.
module tb_mac_seq;

    logic        clk = 1'b0, rst = 1'b0, start = 1'b0;
    logic [7:0]  cfg_len = '0;
    logic        in_valid = 1'b0, res_ready = 1'b1;
    logic [15:0] in_a = '0, in_b = '0;
    logic        busy, in_ready, dsp_aen, dsp_ben, dsp_men, dsp_sen, dsp_sreset;
    logic [15:0] dsp_a_value, dsp_b_value, res_data;
    logic        res_valid, res_sat;
    logic [15:0] dsp_s_out;
    logic        dsp_sat;
`ifdef MAC_SEQ_SAT_CNT_EN
    logic [15:0] sat_cnt;
`endif

    int total = 0;
    int bad   = 0;

    mac_seq #(.LEN_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .dsp_a_value(dsp_a_value), .dsp_b_value(dsp_b_value),
        .dsp_aen(dsp_aen), .dsp_ben(dsp_ben), .dsp_men(dsp_men),
        .dsp_sen(dsp_sen), .dsp_sreset(dsp_sreset),
        .dsp_s_out(dsp_s_out), .dsp_sat(dsp_sat),
`ifdef MAC_SEQ_SAT_CNT_EN
        .sat_cnt(sat_cnt),
`endif
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_sat(res_sat)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Returns {saturated, 16-bit clamped value}.
    function automatic logic [16:0] sat16(input longint v);
        if (v > 32767)       return {1'b1, 16'h7FFF};
        else if (v < -32768) return {1'b1, 16'h8000};
        else                 return {1'b0, 16'(v)};
    endfunction

    // Behavioural MAC cell: operand regs, product reg, wide accumulator, clamped output on sreset.
    logic signed [15:0] c_a, c_b;
    logic signed [31:0] c_m;
    longint             c_acc;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            c_a <= '0; c_b <= '0; c_m <= '0; c_acc <= 0;
            dsp_s_out <= '0; dsp_sat <= 1'b0;
        end else begin
            if (dsp_aen) c_a <= dsp_a_value;
            if (dsp_ben) c_b <= dsp_b_value;
            if (dsp_men) c_m <= c_a * c_b;
            if (dsp_sen) c_acc <= c_acc + longint'(c_m);
            if (dsp_sreset) begin
                c_acc <= 0;
                {dsp_sat, dsp_s_out} <= sat16(c_acc + longint'(c_m));
            end
        end
    end

    // Reference transaction model: pairs in, expected result out.
    logic signed [15:0] pa[$], pb[$];
    logic [15:0] exp_data = '0;
    logic        exp_sat = 1'b0;
    int          exp_sat_cnt = 0;

    function automatic logic [16:0] ref_result();
        longint sum = 0;
        foreach (pa[i]) sum += longint'(pa[i]) * longint'(pb[i]);
        return sat16(sum);
    endfunction

    // Cycle-level timing model, advanced on the falling edge.
    typedef struct packed {
        logic        v;
        logic        last;
        logic [15:0] a;
        logic [15:0] b;
    } stage_t;

    stage_t      h1 = '0, h2 = '0, h3 = '0;
    int          cyc = 0, m_rem = 0, rv_at = -1;
    bit          m_busy = 1'b0, m_rv = 1'b0;
    logic [15:0] prev_a = '0, prev_b = '0;
    int          sen_cnt = 0, sreset_cnt = 0;

    always @(negedge clk) begin
        stage_t s;
        bit     was_idle;
        if (rst) begin
            h1 = '0; h2 = '0; h3 = '0;
            m_rem = 0; m_busy = 1'b0; m_rv = 1'b0; rv_at = -1;
            prev_a = '0; prev_b = '0;
        end else begin
            check("busy", 32'(busy), 32'(m_busy));
            check("in_ready", 32'(in_ready), 32'(m_busy && m_rem != 0));
            check("res_valid", 32'(res_valid), 32'(m_rv));
            check("dsp_aen", 32'(dsp_aen), 32'(h1.v));
            check("dsp_ben", 32'(dsp_ben), 32'(h1.v));
            check("dsp_men", 32'(dsp_men), 32'(h2.v));
            check("dsp_sen", 32'(dsp_sen), 32'(h3.v && !h3.last));
            check("dsp_sreset", 32'(dsp_sreset), 32'(h3.v && h3.last));
            check("dsp_a_value", 32'(dsp_a_value), 32'(h1.v ? h1.a : prev_a));
            check("dsp_b_value", 32'(dsp_b_value), 32'(h1.v ? h1.b : prev_b));
            if (m_rv) begin
                check("res_data", 32'(res_data), 32'(exp_data));
                check("res_sat", 32'(res_sat), 32'(exp_sat));
            end
            if (dsp_sen) sen_cnt++;
            if (dsp_sreset) sreset_cnt++;
            prev_a = dsp_a_value;
            prev_b = dsp_b_value;

            was_idle = !m_busy;
            s = '0;
            if (in_valid && m_busy && m_rem != 0) begin
                s.v    = 1'b1;
                s.last = (m_rem == 1);
                s.a    = in_a;
                s.b    = in_b;
                m_rem--;
                if (s.last) rv_at = cyc + 5;
            end
            h3 = h2; h2 = h1; h1 = s;
            if (m_rv && res_ready) begin
                m_rv   = 1'b0;
                m_busy = 1'b0;
            end
            if (cyc + 1 == rv_at) m_rv = 1'b1;
            if (was_idle && start && cfg_len != 0) begin
                m_busy = 1'b1;
                m_rem  = int'(cfg_len);
            end
        end
        cyc++;
    end

    task automatic feed_pair(input logic [15:0] a, input logic [15:0] b);
        int k = 0;
        in_valid = 1'b1; in_a = a; in_b = b;
        @(negedge clk);
        while (!in_ready && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; in_a = 16'($urandom); in_b = 16'($urandom);
    endtask

    // gap_mode: 0 back-to-back, 1 one idle cycle between pairs, 2 random 0..3 idle cycles.
    task automatic run_txn(input int gap_mode, input int hold);
        int k = 0;
        int len = pa.size();
        {exp_sat, exp_data} = ref_result();
        if (exp_sat) exp_sat_cnt++;
        res_ready = (hold == 0);
        start = 1'b1; cfg_len = 8'(len);
        @(posedge clk); #1;
        start = 1'b0; cfg_len = 8'($urandom);
        for (int i = 0; i < len; i++) begin
            int g = (gap_mode == 1 && i != 0) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 3)) : 0;
            repeat (g) begin
                @(posedge clk); #1;
                in_a = 16'($urandom); in_b = 16'($urandom);
            end
            feed_pair(pa[i], pb[i]);
        end
        @(negedge clk);
        while (!res_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("res_valid_wait", 32'(res_valid), 32'd1);
        check("txn_res_data", 32'(res_data), 32'(exp_data));
        check("txn_res_sat", 32'(res_sat), 32'(exp_sat));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            start = 1'b1; cfg_len = 8'd1;
            @(negedge clk);
            check("hold_res_data", 32'(res_data), 32'(exp_data));
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        if (hold > 0) begin
            @(posedge clk); #1;
            start = 1'b0;
            res_ready = 1'b1;
        end
        @(posedge clk); #1;
        @(negedge clk);
        check("idle_after_handshake", 32'(busy), 32'd0);
        pa.delete(); pb.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_a_value"}, 32'(dsp_a_value), 32'd0);
        check({tag, "_b_value"}, 32'(dsp_b_value), 32'd0);
        check({tag, "_enables"}, 32'({dsp_aen, dsp_ben, dsp_men, dsp_sen, dsp_sreset}), 32'd0);
        check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
        check({tag, "_res_data"}, 32'(res_data), 32'd0);
        check({tag, "_res_sat"}, 32'(res_sat), 32'd0);
`ifdef MAC_SEQ_SAT_CNT_EN
        check({tag, "_sat_cnt"}, 32'(sat_cnt), 32'd0);
`endif
    endtask

    initial begin
        #2 rst = 1'b1;
        #1 check_all_zero("reset");
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Three back-to-back pairs: 6 + 20 - 6 = 20.
        pa = '{16'sd2, 16'sd4, -16'sd1};
        pb = '{16'sd3, 16'sd5, 16'sd6};
        sen_cnt = 0; sreset_cnt = 0;
        run_txn(0, 0);
        check("len3_sen_cycles", 32'(sen_cnt), 32'd2);
        check("len3_sreset_cycles", 32'(sreset_cnt), 32'd1);
        check("len3_result", 32'(exp_data), 32'd20);

        // Positive saturation.
        pa = '{16'sh7FFF, 16'sh7FFF};
        pb = '{16'sh7FFF, 16'sh7FFF};
        run_txn(0, 0);
`ifdef MAC_SEQ_SAT_CNT_EN
        check("sat_cnt_after_sat", 32'(sat_cnt), 32'd1);
`endif

        // Gapped input: -30 + 49 - 1000 + 30000.
        pa = '{16'sd10, 16'sd7, -16'sd200, 16'sd1000};
        pb = '{-16'sd3, 16'sd7, 16'sd5, 16'sd30};
        run_txn(1, 0);

        // Result held under back-pressure, start ignored meanwhile.
        pa = '{16'sd100, -16'sd5};
        pb = '{16'sd2, 16'sd4};
        run_txn(0, 10);

        // Zero-length start is ignored.
        @(posedge clk); #1;
        start = 1'b1; cfg_len = 8'd0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("len0_busy", 32'(busy), 32'd0);
        check("len0_enables", 32'({dsp_aen, dsp_men, dsp_sen, dsp_sreset}), 32'd0);

        // Reset in the middle of a 4-pair operation.
        @(posedge clk); #1;
        start = 1'b1; cfg_len = 8'd4;
        @(posedge clk); #1;
        start = 1'b0;
        feed_pair(16'sd11, 16'sd12);
        feed_pair(-16'sd13, 16'sd14);
        rst = 1'b1; in_valid = 1'b0;
        #1 check_all_zero("midrst");
        @(negedge clk);
        check_all_zero("midrst_hold");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        exp_sat_cnt = 0;
        pa = '{16'sd3};
        pb = '{-16'sd7};
        run_txn(0, 0);
        check("post_reset_result", 32'(res_data), 32'hFFEB);

        // Random transactions.
        for (int t = 0; t < 12; t++) begin
            int len = int'($urandom_range(1, 6));
            bit big = 1'($urandom);
            for (int i = 0; i < len; i++) begin
                if (big) begin
                    pa.push_back(16'($urandom));
                    pb.push_back(16'($urandom));
                end else begin
                    pa.push_back(16'(int'($urandom_range(0, 400)) - 200));
                    pb.push_back(16'(int'($urandom_range(0, 400)) - 200));
                end
            end
            run_txn(int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
        end
`ifdef MAC_SEQ_SAT_CNT_EN
        check("sat_cnt_final", 32'(sat_cnt), 32'(exp_sat_cnt));
`endif

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
